counter_checker: RTL and testbench

COUNTER_CHECKER -- requirements
Module: counter_checker

---
 rtl/loopback_pkg.sv | 12 +
 rtl/counter_checker.sv | 204 ++++++++++++++++++++
 tb/tb_counter_checker.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/loopback_pkg.sv
// Shared definitions for the counter-pattern loopback checker and its data generator tooling.
package loopback_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        SETTLE = 2'd2
    } chk_state_t;

    localparam int SETTLE_LEN = 8;

endpackage

// File: rtl/counter_checker.sv
// Locks onto an incrementing counter stream, then counts good and bad words.
// Bitslip request and SETTLE recovery are built only when COUNTER_CHECKER_BITSLIP_EN is defined.
module counter_checker
    import loopback_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int LOCK_CNT     = 16,
    parameter int LOSS_CNT     = 4,
    parameter int ERR_W        = 16,
    parameter int SLIP_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clear_cnt,
    output logic              locked,
    output logic              lock_lost,
    output logic [ERR_W-1:0]  err_count,
    output logic [31:0]       word_count,
    output logic              bitslip
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);
    localparam logic [RUN_W-1:0]  LOCK_LAST = RUN_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_CNT - 1);

    if (LOCK_CNT < 1 || LOSS_CNT < 1 || ERR_W < 1 || SLIP_TIMEOUT < 1) begin : g_param_check
        $error("counter_checker: LOCK_CNT, LOSS_CNT, ERR_W and SLIP_TIMEOUT must be >= 1");
    end

    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    function automatic logic [31:0] sat_inc_word(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    chk_state_t        state, state_n;
    logic [DATA_W-1:0] prev, prev_n;
    logic [DATA_W-1:0] expected, expected_n;
    logic              prev_vld, prev_vld_n;
    logic [RUN_W-1:0]  run_cnt, run_n;
    logic [MISS_W-1:0] miss_cnt, miss_n;
    logic              locked_n, lost_n;
    logic [ERR_W-1:0]  err_n;
    logic [31:0]       word_n;

    logic [DATA_W-1:0] prev_inc, exp_inc, data_inc;
    assign prev_inc = prev + DATA_W'(1);
    assign exp_inc  = expected + DATA_W'(1);
    assign data_inc = data_in + DATA_W'(1);

`ifdef COUNTER_CHECKER_BITSLIP_EN
    localparam int TO_W     = $clog2(SLIP_TIMEOUT + 1);
    localparam int SETTLE_W = $clog2(SETTLE_LEN);
    localparam logic [TO_W-1:0]     TO_LAST     = TO_W'(SLIP_TIMEOUT - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_LEN - 1);

    logic [TO_W-1:0]     to_cnt, to_n;
    logic [SETTLE_W-1:0] settle_cnt, settle_n;
    logic                slip_n;
`endif

    always_comb begin
        state_n    = state;
        prev_n     = prev;
        prev_vld_n = prev_vld;
        expected_n = expected;
        run_n      = run_cnt;
        miss_n     = miss_cnt;
        locked_n   = locked;
        lost_n     = lock_lost;
        err_n      = err_count;
        word_n     = word_count;
`ifdef COUNTER_CHECKER_BITSLIP_EN
        to_n       = to_cnt;
        settle_n   = settle_cnt;
        slip_n     = 1'b0;
`endif
        case (state)
            SEARCH: begin
                if (data_valid) begin
                    prev_n     = data_in;
                    prev_vld_n = 1'b1;
`ifdef COUNTER_CHECKER_BITSLIP_EN
                    to_n       = to_cnt + TO_W'(1);
`endif
                    // The first word after entry only seeds prev; it never counts as a match.
                    if (prev_vld && data_in == prev_inc) begin
                        if (run_cnt == LOCK_LAST) begin
                            state_n    = LOCKED;
                            locked_n   = 1'b1;
                            expected_n = data_inc;
                            run_n      = '0;
                            miss_n     = '0;
                        end else begin
                            run_n = run_cnt + RUN_W'(1);
                        end
                    end else begin
                        run_n = '0;
                    end
`ifdef COUNTER_CHECKER_BITSLIP_EN
                    if (state_n == SEARCH && to_cnt == TO_LAST) begin
                        state_n  = SETTLE;
                        slip_n   = 1'b1;
                        settle_n = '0;
                        to_n     = '0;
                    end
`endif
                end
            end
            LOCKED: begin
                if (data_valid) begin
                    if (data_in == expected) begin
                        expected_n = data_inc;
                        word_n     = sat_inc_word(word_count);
                        miss_n     = '0;
                    end else begin
                        // Free-run the expectation so a single bad word does not shift alignment.
                        expected_n = exp_inc;
                        err_n      = sat_inc_err(err_count);
                        if (miss_cnt == MISS_LAST) begin
                            state_n    = SEARCH;
                            locked_n   = 1'b0;
                            lost_n     = 1'b1;
                            prev_vld_n = 1'b0;
                            run_n      = '0;
                            miss_n     = '0;
`ifdef COUNTER_CHECKER_BITSLIP_EN
                            to_n       = '0;
`endif
                        end else begin
                            miss_n = miss_cnt + MISS_W'(1);
                        end
                    end
                end
            end
`ifdef COUNTER_CHECKER_BITSLIP_EN
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_n    = SEARCH;
                    prev_vld_n = 1'b0;
                    run_n      = '0;
                    to_n       = '0;
                end else begin
                    settle_n = settle_cnt + SETTLE_W'(1);
                end
            end
`endif
            default: state_n = SEARCH;
        endcase

        if (clear_cnt) begin
            err_n  = '0;
            word_n = '0;
            lost_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEARCH;
            prev_vld   <= 1'b0;
            run_cnt    <= '0;
            miss_cnt   <= '0;
            locked     <= 1'b0;
            lock_lost  <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
`ifdef COUNTER_CHECKER_BITSLIP_EN
            to_cnt     <= '0;
            settle_cnt <= '0;
            bitslip    <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            prev_vld   <= prev_vld_n;
            run_cnt    <= run_n;
            miss_cnt   <= miss_n;
            locked     <= locked_n;
            lock_lost  <= lost_n;
            err_count  <= err_n;
            word_count <= word_n;
`ifdef COUNTER_CHECKER_BITSLIP_EN
            to_cnt     <= to_n;
            settle_cnt <= settle_n;
            bitslip    <= slip_n;
`endif
        end
    end

    always_ff @(posedge clk) begin
        prev     <= prev_n;
        expected <= expected_n;
    end

`ifndef COUNTER_CHECKER_BITSLIP_EN
    assign bitslip = 1'b0;
`endif

endmodule

// File: tb/tb_counter_checker.sv
// Randomized self-checking bench for counter_checker with a behavioural reference model.
module tb_counter_checker;

    localparam int DATA_W       = 8;
    localparam int LOCK_CNT     = 16;
    localparam int LOSS_CNT     = 4;
    localparam int ERR_W        = 4;
    localparam int SLIP_TIMEOUT = 64;
    localparam int SETTLE_CYC   = 8;
    localparam longint ERR_MAX  = (64'd1 << ERR_W) - 1;
    localparam longint WORD_MAX = 64'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst;
    logic              data_valid;
    logic [DATA_W-1:0] data_in;
    logic              clear_cnt;
    logic              locked;
    logic              lock_lost;
    logic [ERR_W-1:0]  err_count;
    logic [31:0]       word_count;
    logic              bitslip;

    always #5 clk = ~clk;

    counter_checker #(
        .DATA_W      (DATA_W),
        .LOCK_CNT    (LOCK_CNT),
        .LOSS_CNT    (LOSS_CNT),
        .ERR_W       (ERR_W),
        .SLIP_TIMEOUT(SLIP_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_valid(data_valid),
        .data_in   (data_in),
        .clear_cnt (clear_cnt),
        .locked    (locked),
        .lock_lost (lock_lost),
        .err_count (err_count),
        .word_count(word_count),
        .bitslip   (bitslip)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the outputs must be after each rising edge.
    bit     m_locked, m_lost, m_slip, m_has_last;
    int     m_last, m_run, m_exp, m_miss, m_to, m_settle;
    longint m_err, m_word;

    always @(posedge clk) begin
        m_slip = 1'b0;
        if (rst) begin
            m_locked = 0; m_lost = 0; m_has_last = 0;
            m_run = 0; m_miss = 0; m_to = 0; m_settle = 0;
            m_err = 0; m_word = 0;
        end else begin
            if (m_settle > 0) begin
                m_settle--;
                if (m_settle == 0) begin
                    m_has_last = 0; m_run = 0; m_to = 0;
                end
            end else if (data_valid) begin
                if (!m_locked) begin
                    m_to++;
                    if (m_has_last && int'(data_in) == (m_last + 1) % 256) m_run++;
                    else m_run = 0;
                    m_has_last = 1;
                    m_last = int'(data_in);
                    if (m_run == LOCK_CNT) begin
                        m_locked = 1; m_exp = (int'(data_in) + 1) % 256; m_miss = 0; m_run = 0;
                    end
`ifdef COUNTER_CHECKER_BITSLIP_EN
                    else if (m_to == SLIP_TIMEOUT) begin
                        m_slip = 1; m_settle = SETTLE_CYC; m_to = 0;
                    end
`endif
                end else begin
                    if (int'(data_in) == m_exp) begin
                        if (m_word < WORD_MAX) m_word++;
                        m_miss = 0;
                    end else begin
                        if (m_err < ERR_MAX) m_err++;
                        m_miss++;
                    end
                    m_exp = (m_exp + 1) % 256;
                    if (m_miss == LOSS_CNT) begin
                        m_locked = 0; m_lost = 1; m_has_last = 0;
                        m_run = 0; m_to = 0; m_miss = 0;
                    end
                end
            end
            if (clear_cnt) begin
                m_err = 0; m_word = 0; m_lost = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("locked", locked, m_locked);
            chk("lock_lost", lock_lost, m_lost);
            chk("err_count", err_count, m_err);
            chk("word_count", word_count, m_word);
            chk("bitslip", bitslip, m_slip);
        end
    end

    task automatic cyc(input bit v, input int d, input bit c, input bit r);
        data_valid = v;
        data_in    = d[DATA_W-1:0];
        clear_cnt  = c;
        rst        = r;
        @(negedge clk);
    endtask

    int  cnt, burst, d, slips, i;
    bit  v, c, r;

    initial begin
        rst = 1'b1; data_valid = 1'b0; data_in = '0; clear_cnt = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        cyc(0, 0, 0, 1);
        chk("rst_locked", locked, 0);
        chk("rst_err", err_count, 0);
        chk("rst_word", word_count, 0);
        chk("rst_lost", lock_lost, 0);

        // Counter stream 0x00..0x1F: lock one cycle after 0x10
        for (int k = 0; k <= 'h1F; k++) begin
            cyc(1, k, 0, 0);
            if (k == 'h0F) chk("lock_early", locked, 0);
            if (k == 'h10) chk("lock_at_0x10", locked, 1);
        end
        chk("word_after_1f", word_count, 15);
        chk("err_after_1f", err_count, 0);

        // Wrap through 0xFF -> 0x00 -> 0x01
        for (int k = 'h20; k <= 'h101; k++) cyc(1, k % 256, 0, 0);
        chk("wrap_locked", locked, 1);
        chk("wrap_err", err_count, 0);
        chk("wrap_word", word_count, 241);

        // Single corrupted word: 0x42 replaced by 0x00
        for (int k = 'h02; k <= 'h41; k++) cyc(1, k, 0, 0);
        cyc(1, 'h00, 0, 0);
        chk("corrupt_err", err_count, 1);
        chk("corrupt_locked", locked, 1);
        cyc(1, 'h43, 0, 0);
        chk("resume_word", word_count, 306);

        // Four consecutive wrong words drop lock
        for (int k = 0; k < 4; k++) begin
            cyc(1, 'h10, 0, 0);
            if (k == 2) chk("loss_third", locked, 1);
        end
        chk("loss_locked", locked, 0);
        chk("loss_sticky", lock_lost, 1);
        chk("loss_err", err_count, 5);

        // Relock, then clear_cnt together with an error
        for (int k = 0; k <= 'h10; k++) cyc(1, k, 0, 0);
        chk("relock", locked, 1);
        cyc(1, 'h99, 1, 0);
        chk("clear_err", err_count, 0);
        chk("clear_lost", lock_lost, 0);
        chk("clear_word", word_count, 0);
        chk("clear_keeps_lock", locked, 1);

        // Gaps in the valid stream
        cyc(0, 0, 0, 1);
        i = 0;
        while (i <= 'h14) begin
            if ($urandom_range(0, 1) == 1) begin
                cyc(1, i, 0, 0);
                if (i == 'h0F) chk("gap_lock_early", locked, 0);
                if (i == 'h10) chk("gap_lock", locked, 1);
                i++;
            end else begin
                cyc(0, $urandom_range(0, 255), 0, 0);
            end
        end
        chk("gap_err", err_count, 0);
        chk("gap_word", word_count, 4);

        // Non-incrementing data (step of 2) for longer than the slip timeout
        cyc(0, 0, 0, 1);
        slips = 0;
        for (int k = 0; k < SLIP_TIMEOUT + SETTLE_CYC + 4; k++) begin
            cyc(1, (2 * k) % 256, 0, 0);
            if (bitslip) slips++;
        end
`ifdef COUNTER_CHECKER_BITSLIP_EN
        chk("slip_pulses", slips, 1);
`else
        chk("slip_pulses", slips, 0);
`endif

        // Random traffic: gaps, corruptions, error bursts, jumps, clears, rare resets
        cyc(0, 0, 0, 1);
        cnt = 0; burst = 0;
        repeat (4000) begin
            v = ($urandom_range(0, 3) != 0);
            d = cnt;
            if (burst > 0) begin
                d = $urandom_range(0, 255);
                if (v) burst--;
            end else if ($urandom_range(0, 39) == 0) begin
                d = $urandom_range(0, 255);
            end else if ($urandom_range(0, 299) == 0) begin
                burst = $urandom_range(1, 6);
            end else if ($urandom_range(0, 499) == 0) begin
                cnt = $urandom_range(0, 255);
                d = cnt;
            end
            c = ($urandom_range(0, 99) == 0);
            r = ($urandom_range(0, 999) == 0);
            cyc(v, d, c, r);
            if (v) cnt = (cnt + 1) % 256;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
